search_ctrl: RTL

Sequencing controller for the linear key search over the data memory. On `start` it takes ownership of the memory port, reads entries 0..`last_addr` one at a time, compares each read word against `key` and stops on the first match or at the end of the range. It reports `found`/`found_addr` and drives the ownership select into the external/controller memory-control muxes, so external writes and controller reads never overlap.

---
 rtl/search_ctrl.sv | 121 ++++++++++++
 1 files changed

// File: rtl/search_ctrl.sv
// search_ctrl: linear key search over the data memory, with first-match-wins
// reporting. Defining SEARCH_CTRL_ABORT_EN adds an abort input.
module search_ctrl #(
    parameter int A = 8,
    parameter int D = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [D-1:0] key,
    input  logic [A-1:0] last_addr,
    input  logic [D-1:0] mem_q,
`ifdef SEARCH_CTRL_ABORT_EN
    input  logic         abort,
`endif
    output logic         mem_ce,
    output logic         mem_we,
    output logic [A-1:0] mem_addr,
    output logic         sel_ctu,
    output logic         busy,
    output logic         done,
    output logic         found,
    output logic [A-1:0] found_addr
);

    // state  | meaning
    // IDLE   | external port owns memory, waiting for start
    // READ   | read issued at cnt
    // CMP    | mem_q compared with key_r
    // DONE   | single-cycle completion pulse
    typedef enum logic [1:0] {S_IDLE, S_READ, S_CMP, S_DONE} state_t;

    state_t       state, state_nxt;
    logic [A-1:0] cnt, cnt_nxt;
    logic [A-1:0] last_r, last_nxt;
    logic [D-1:0] key_r, key_nxt;
    logic         found_nxt;
    logic [A-1:0] found_addr_nxt;
    logic         abort_req;

`ifdef SEARCH_CTRL_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        last_nxt       = last_r;
        key_nxt        = key_r;
        found_nxt      = found;
        found_addr_nxt = found_addr;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt      = S_READ;
                    cnt_nxt        = '0;
                    key_nxt        = key;
                    last_nxt       = last_addr;
                    found_nxt      = 1'b0;
                    found_addr_nxt = '0;
                end
            end
            S_READ: begin
                if (abort_req) begin
                    state_nxt      = S_DONE;
                    found_nxt      = 1'b0;
                    found_addr_nxt = '0;
                end else begin
                    state_nxt = S_CMP;
                end
            end
            S_CMP: begin
                // abort outranks a match landing in the same cycle
                if (abort_req) begin
                    state_nxt      = S_DONE;
                    found_nxt      = 1'b0;
                    found_addr_nxt = '0;
                end else if (mem_q == key_r) begin
                    state_nxt      = S_DONE;
                    found_nxt      = 1'b1;
                    found_addr_nxt = cnt;
                end else if (cnt == last_r) begin
                    state_nxt = S_DONE;
                end else begin
                    state_nxt = S_READ;
                    cnt_nxt   = cnt + A'(1);
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= S_IDLE;
            cnt        <= '0;
            last_r     <= '0;
            key_r      <= '0;
            found      <= 1'b0;
            found_addr <= '0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            last_r     <= last_nxt;
            key_r      <= key_nxt;
            found      <= found_nxt;
            found_addr <= found_addr_nxt;
        end
    end

    assign busy     = (state != S_IDLE);
    assign sel_ctu  = busy;
    assign mem_ce   = (state == S_READ);
    assign mem_we   = 1'b0;
    assign mem_addr = cnt;
    assign done     = (state == S_DONE);

endmodule
